// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU sequencer: FSM states, instruction
// field positions and the default memory wait limit.
package hack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_COMMIT,
    ST_ERROR
  } state_e;

  localparam int unsigned C_BIT  = 15;  // 1 = C-instruction, 0 = A-instruction
  localparam int unsigned A_BIT  = 12;  // ALU operand selects M instead of A
  localparam int unsigned D3_BIT = 3;   // destination includes M (write)
  localparam int unsigned J1_BIT = 2;   // jump if out < 0
  localparam int unsigned J2_BIT = 1;   // jump if out = 0
  localparam int unsigned J3_BIT = 0;   // jump if out > 0

  localparam int unsigned WAIT_LIMIT_DEFAULT = 15;

endpackage

// File: rtl/hack_cpu_sequencer_if.sv
// Instruction- and data-memory handshake bundle between the sequencer
// (master) and the memory subsystem (slave).
interface hack_cpu_sequencer_if;

  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack
  );

endinterface

// File: rtl/hack_jump_unit.sv
// Jump decision for a committed instruction: C-instructions jump when any
// selected condition (lt / eq / gt) matches the ALU flags.
module hack_jump_unit
  import hack_pkg::*;
(
  input  logic       c_instr,
  input  logic [2:0] jbits,
  input  logic       alu_zr,
  input  logic       alu_ng,
  output logic       taken
);

  always_comb begin
    taken = c_instr & ((jbits[J1_BIT] & alu_ng) |
                       (jbits[J2_BIT] & alu_zr) |
                       (jbits[J3_BIT] & ~alu_ng & ~alu_zr));
  end

endmodule

// File: rtl/hack_cpu_sequencer.sv
// Hack CPU control sequencer: fetch / execute / memory / commit FSM with
// bounded memory waits, a sticky timeout error and program-counter control.
module hack_cpu_sequencer
  import hack_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset_n,
  hack_cpu_sequencer_if.master        mem,
  input  logic                        alu_zr,
  input  logic                        alu_ng,
  input  logic [15:0]                 a_reg,
  input  logic [15:0]                 pc_cur,
  output logic                        pc_we,
  output logic [15:0]                 pc_in,
  output logic [15:0]                 instr,
  output logic                        exec_en,
  output logic                        error
);

  // Last wait count that may still be followed by an ack before timing out.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [15:0] instr_q, instr_d;
  logic        needs_mem;
  logic        taken;

  assign needs_mem = instr_q[C_BIT] & (instr_q[A_BIT] | instr_q[D3_BIT]);
  assign instr     = instr_q;

  hack_jump_unit u_jump (
    .c_instr (instr_q[C_BIT]),
    .jbits   (instr_q[2:0]),
    .alu_zr  (alu_zr),
    .alu_ng  (alu_ng),
    .taken   (taken)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      instr_q <= instr_d;
    end
  end

  // The counter is zero outside FETCH/MEM, so it is already clear on entry.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    instr_d = instr_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem.imem_ack) begin
          instr_d = mem.imem_rdata;
          state_d = ST_EXEC;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_q == WAIT_LAST) state_d = ST_ERROR;
        end
      end
      ST_EXEC: state_d = needs_mem ? ST_MEM : ST_COMMIT;
      ST_MEM: begin
        if (mem.dmem_ack) begin
          state_d = ST_COMMIT;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_q == WAIT_LAST) state_d = ST_ERROR;
        end
      end
      ST_COMMIT: state_d = ST_FETCH;
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    exec_en      = 1'b0;
    error        = 1'b0;
    pc_we        = 1'b1;
    pc_in        = pc_cur;
    case (state_q)
      ST_FETCH: mem.imem_req = 1'b1;
      ST_MEM: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = instr_q[D3_BIT];
      end
      ST_COMMIT: begin
        exec_en = 1'b1;
        if (taken) pc_in = a_reg;
        else       pc_we = 1'b0;
      end
      ST_ERROR: error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hack_cpu_sequencer.sv
// Self-checking bench: random instruction stream with random memory latency,
// checked against an instruction-level reference of the sequencer.
module tb_hack_cpu_sequencer;

  localparam int unsigned WL = 15;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_zr, alu_ng;
  logic [15:0] a_reg, pc_cur, pc_in, instr;
  logic        pc_we, exec_en, error;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [15:0] exp_pc;

  hack_cpu_sequencer_if mem_if ();

  hack_cpu_sequencer #(.WAIT_LIMIT(WL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mem     (mem_if),
    .alu_zr  (alu_zr),
    .alu_ng  (alu_ng),
    .a_reg   (a_reg),
    .pc_cur  (pc_cur),
    .pc_we   (pc_we),
    .pc_in   (pc_in),
    .instr   (instr),
    .exec_en (exec_en),
    .error   (error)
  );

  always #5 clk = ~clk;

  // Program counter of the surrounding CPU: load when pc_we, else increment.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)   pc_cur <= '0;
    else if (pc_we) pc_cur <= pc_in;
    else            pc_cur <= pc_cur + 16'd1;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Advance to the next falling edge and put noise on inputs the current
  // state must ignore; callers override what matters before sampling.
  task automatic step();
    @(negedge clk);
    mem_if.imem_ack   = 1'($urandom_range(0, 1));
    mem_if.dmem_ack   = 1'($urandom_range(0, 1));
    mem_if.imem_rdata = 16'($urandom);
    alu_zr            = 1'($urandom_range(0, 1));
    alu_ng            = 1'($urandom_range(0, 1));
    a_reg             = 16'($urandom);
  endtask

  task automatic chk_hold(input string tag);
    chk_eq({tag, "_pcwe"}, pc_we, 1'b1);
    chk_eq({tag, "_pcin"}, pc_in, exp_pc);
    chk_eq({tag, "_exec"}, exec_en, 1'b0);
  endtask

  task automatic fetch_exec(input logic [15:0] word, input int unsigned fd);
    for (int unsigned k = 0; k <= fd; k++) begin
      step();
      mem_if.imem_ack = (k == fd);
      if (k == fd) mem_if.imem_rdata = word;
      #1;
      if (k == 0) chk_eq("fetch_pc", pc_cur, exp_pc);
      chk_eq("fetch_ireq", mem_if.imem_req, 1'b1);
      chk_eq("fetch_dreq", mem_if.dmem_req, 1'b0);
      chk_eq("fetch_err", error, 1'b0);
      chk_hold("fetch");
    end
    step();
    #1;
    chk_eq("exec_instr", instr, word);
    chk_eq("exec_ireq", mem_if.imem_req, 1'b0);
    chk_eq("exec_dreq", mem_if.dmem_req, 1'b0);
    chk_hold("exec");
  endtask

  // fl: 0 = ALU result negative, 1 = zero, 2 = positive.
  task automatic run_instr(input logic [15:0] word, input int unsigned fd,
                           input int unsigned md, input int unsigned fl,
                           input logic [15:0] areg);
    bit is_c, uses_m, jump;
    is_c   = word[15];
    uses_m = is_c && (word[12] || word[3]);
    jump   = is_c && ((word[2] && fl == 0) || (word[1] && fl == 1) || (word[0] && fl == 2));
    fetch_exec(word, fd);
    if (uses_m) begin
      for (int unsigned k = 0; k <= md; k++) begin
        step();
        mem_if.dmem_ack   = (k == md);
        mem_if.imem_ack   = 1'b1;
        mem_if.imem_rdata = ~word;
        #1;
        chk_eq("mem_dreq", mem_if.dmem_req, 1'b1);
        chk_eq("mem_dwe", mem_if.dmem_we, word[3]);
        chk_eq("mem_ireq", mem_if.imem_req, 1'b0);
        chk_eq("mem_instr", instr, word);
        chk_hold("mem");
      end
    end
    step();
    alu_ng = (fl == 0);
    alu_zr = (fl == 1);
    a_reg  = areg;
    #1;
    chk_eq("commit_exec", exec_en, 1'b1);
    chk_eq("commit_ireq", mem_if.imem_req, 1'b0);
    chk_eq("commit_dreq", mem_if.dmem_req, 1'b0);
    chk_eq("commit_pcwe", pc_we, jump);
    if (jump) chk_eq("commit_pcin", pc_in, areg);
    exp_pc = jump ? areg : exp_pc + 16'd1;
  endtask

  task automatic chk_error_hold(input int unsigned cycles);
    for (int unsigned k = 0; k < cycles; k++) begin
      step();
      #1;
      chk_eq("err_flag", error, 1'b1);
      chk_eq("err_ireq", mem_if.imem_req, 1'b0);
      chk_eq("err_dreq", mem_if.dmem_req, 1'b0);
      chk_eq("err_pc", pc_cur, exp_pc);
      chk_hold("err");
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    mem_if.imem_ack = 1'b1;
    mem_if.dmem_ack = 1'b1;
    #1;
    chk_eq("rst_instr", instr, 16'h0000);
    chk_eq("rst_ireq", mem_if.imem_req, 1'b0);
    chk_eq("rst_dreq", mem_if.dmem_req, 1'b0);
    chk_eq("rst_dwe", mem_if.dmem_we, 1'b0);
    chk_eq("rst_exec", exec_en, 1'b0);
    chk_eq("rst_err", error, 1'b0);
    chk_eq("rst_pcwe", pc_we, 1'b1);
    chk_eq("rst_pcin", pc_in, 16'h0000);
    for (int unsigned k = 0; k < 2; k++) begin
      step();
      #1;
      chk_eq("rst_hold_exec", exec_en, 1'b0);
    end
    step();
    reset_n = 1'b1;
    #1;
    chk_eq("idle_ireq", mem_if.imem_req, 1'b0);
    chk_eq("idle_exec", exec_en, 1'b0);
    exp_pc = 16'h0000;
  endtask

  task automatic run_random(input int unsigned count);
    logic [15:0] w;
    int unsigned fd, md;
    for (int unsigned i = 0; i < count; i++) begin
      w  = ($urandom_range(0, 1) == 1) ? {3'b111, 13'($urandom)} : {1'b0, 15'($urandom)};
      fd = ($urandom_range(0, 9) == 0) ? WL - 1 : $urandom_range(0, 4);
      md = ($urandom_range(0, 9) == 0) ? WL - 1 : $urandom_range(0, 4);
      run_instr(w, fd, md, $urandom_range(0, 2), 16'($urandom));
    end
  endtask

  initial begin
    reset_n           = 1'b1;
    mem_if.imem_ack   = 1'b0;
    mem_if.dmem_ack   = 1'b0;
    mem_if.imem_rdata = '0;
    alu_zr            = 1'b0;
    alu_ng            = 1'b0;
    a_reg             = '0;
    exp_pc            = '0;

    do_reset();
    run_instr(16'h0005, 2, 0, 2, 16'h1111);      // A-instr, ack on 3rd cycle
    run_instr(16'hE302, 0, 0, 1, 16'h0040);      // D;JEQ with zero -> 0x0040
    run_instr(16'hFC08, 0, 3, 2, 16'h2222);      // M=M, 4 cycles of dmem_req
    run_instr(16'h0123, WL - 1, 0, 0, 16'h3333); // ack on the last allowed cycle
    run_instr(16'hE307, 0, 0, 0, 16'hFFFF);      // unconditional jump to 0xFFFF
    run_instr(16'h1234, 1, 0, 1, 16'h4444);      // PC wraps to 0x0000
    run_random(150);

    // Reset in the middle of a data access.
    fetch_exec(16'hFC08, 0);
    step();
    mem_if.dmem_ack = 1'b0;
    #1;
    chk_eq("pre_rst_dreq", mem_if.dmem_req, 1'b1);
    do_reset();
    run_instr(16'h0007, 1, 0, 1, 16'h5555);

    // Fetch timeout.
    for (int unsigned k = 0; k < WL; k++) begin
      step();
      mem_if.imem_ack = 1'b0;
      #1;
      chk_eq("to_fetch_ireq", mem_if.imem_req, 1'b1);
    end
    chk_error_hold(5);
    do_reset();
    run_random(20);

    // Data-memory timeout.
    fetch_exec(16'hF008, 1);
    for (int unsigned k = 0; k < WL; k++) begin
      step();
      mem_if.dmem_ack = 1'b0;
      #1;
      chk_eq("to_mem_dreq", mem_if.dmem_req, 1'b1);
    end
    chk_error_hold(5);
    do_reset();
    run_random(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
